// File: rtl/osu_clkdiv_pkg.sv
// Shared definitions for the osu_clkdiv_gen clock divider.
//   state_t : controller states (IDLE, RUN, DRAIN)
//   DIV_MIN : smallest legal divisor; requested values below it are clamped
package osu_clkdiv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/osu_clkdiv_halfcyc.sv
// Half-cycle extension stage for odd divisors.
// A falling-edge flop re-samples the registered divided clock. ORing it back
// in stretches the high phase by half a root-clock cycle, which gives a 50%
// duty cycle for odd divisors. For even divisors the delayed copy is masked.
// Ports:
//   CLK     root clock (falling edge used here)
//   RN      asynchronous active-low reset
//   q_pos   registered divided clock from the rising-edge domain
//   odd     active divisor is odd
//   clk_out divided clock with odd-N duty correction
import osu_clkdiv_pkg::*;

module osu_clkdiv_halfcyc (
    input  logic CLK,
    input  logic RN,
    input  logic q_pos,
    input  logic odd,
    output logic clk_out
);

    logic q_neg;

    always_ff @(negedge CLK or negedge RN) begin
        if (!RN) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= q_pos;
        end
    end

    assign clk_out = q_pos | (q_neg & odd);

endmodule

// File: rtl/osu_clkdiv_gen.sv
// Programmable glitch-free synchronous clock divider.
// Produces a divided clock CLKOUT and a TICK strobe on each CLKOUT rising
// edge. The divisor changes through a REQ/ACK handshake and only takes effect
// on a period boundary; stopping (EN low) always completes the current period.
// Ports:
//   CLK    root clock          RN     async active-low reset
//   EN     run request         DIV    requested divisor (0/1 clamp to 2)
//   REQ    divisor change req  ACK    one-cycle capture acknowledge
//   CLKOUT divided clock       TICK   pulse with each CLKOUT rising edge
//   BUSY   controller not idle
// Optional feature: define CLKDIV_ODD50_EN for 50% duty on odd divisors.
// Asserting RN mid-period can cut a CLKOUT high phase short (runt pulse).
import osu_clkdiv_pkg::*;

module osu_clkdiv_gen #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             EN,
    input  logic [WIDTH-1:0] DIV,
    input  logic             REQ,
    output logic             ACK,
    output logic             CLKOUT,
    output logic             TICK,
    output logic             BUSY
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             ack_q, ack_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] div_eff;
    logic             boundary;

    assign div_eff  = (DIV < WIDTH'(DIV_MIN)) ? WIDTH'(DIV_MIN) : DIV;
    assign boundary = (state_q != IDLE) && (cnt_q == n_q - WIDTH'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        tick_d  = 1'b0;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (REQ) begin
                    n_d   = div_eff;
                    ack_d = 1'b1;
                end
                if (EN) begin
                    state_d = RUN;
                    tick_d  = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (boundary) begin
                    cnt_d = '0;
                    if (REQ) begin
                        n_d   = div_eff;
                        ack_d = 1'b1;
                    end
                    // Only a drain that is still unwanted at the boundary stops;
                    // any other boundary opens a fresh period.
                    if (state_q == DRAIN && !EN) begin
                        state_d = IDLE;
                    end else begin
                        state_d = EN ? RUN : DRAIN;
                        tick_d  = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + WIDTH'(1);
                    state_d = EN ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Output follows the post-edge count and divisor so it is registered.
        clk_d  = (state_d != IDLE) && (cnt_d < (n_d >> 1));
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= WIDTH'(DIV_MIN);
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    assign ACK  = ack_q;
    assign TICK = tick_q;
    assign BUSY = busy_q;

`ifdef CLKDIV_ODD50_EN
    osu_clkdiv_halfcyc u_halfcyc (
        .CLK     (CLK),
        .RN      (RN),
        .q_pos   (clk_q),
        .odd     (n_q[0]),
        .clk_out (CLKOUT)
    );
`else
    assign CLKOUT = clk_q;
`endif

endmodule

// File: tb/tb_osu_clkdiv_gen.sv
module tb_osu_clkdiv_gen;

    logic       CLK = 1'b0;
    logic       RN  = 1'b0;
    logic       EN  = 1'b0;
    logic [7:0] DIV = '0;
    logic       REQ = 1'b0;
    logic       ACK, CLKOUT, TICK, BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    osu_clkdiv_gen #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RN     (RN),
        .EN     (EN),
        .DIV    (DIV),
        .REQ    (REQ),
        .ACK    (ACK),
        .CLKOUT (CLKOUT),
        .TICK   (TICK),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: activity flag, stop-pending flag, position in period.
    bit m_active, m_stopping, m_clk, m_prev, m_tick, m_ack;
    int m_pos, m_n;

    function automatic void model_reset();
        m_active = 0; m_stopping = 0; m_clk = 0; m_prev = 0;
        m_tick = 0; m_ack = 0; m_pos = 0; m_n = 2;
    endfunction

    function automatic void model_edge(bit en, bit req, int div);
        int eff;
        eff    = (div < 2) ? 2 : div;
        m_prev = m_clk;
        m_ack  = 0;
        m_tick = 0;
        if (!m_active) begin
            if (req) begin m_n = eff; m_ack = 1; end
            if (en) begin m_active = 1; m_pos = 0; m_tick = 1; end
        end else begin
            if (m_pos == m_n - 1) begin
                if (req) begin m_n = eff; m_ack = 1; end
                m_pos = 0;
                if (m_stopping && !en) m_active = 0;
                else m_tick = 1;
            end else begin
                m_pos = m_pos + 1;
            end
        end
        m_stopping = m_active && !en;
        m_clk = m_active && (m_pos < m_n / 2);
    endfunction

    function automatic bit model_clkout();
`ifdef CLKDIV_ODD50_EN
        return m_clk | (m_prev & (m_n % 2 == 1));
`else
        return m_clk;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge(EN, REQ, int'(DIV));
        #1;
        chk("clkout", CLKOUT, model_clkout());
        chk("tick", TICK, m_tick);
        chk("ack", ACK, m_ack);
        chk("busy", BUSY, m_active);
    endtask

    task automatic go_idle();
        EN = 1'b0;
        REQ = 1'b0;
        for (int i = 0; i < 600 && BUSY; i++) step();
        chk("go_idle", BUSY, 0);
    endtask

    task automatic load(input logic [7:0] d);
        DIV = d;
        REQ = 1'b1;
        step();
        chk("ack_idle", ACK, 1);
        REQ = 1'b0;
    endtask

    typedef struct {
        logic [7:0] div;
        int         exp_n;
        int         exp_high;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int k, highs, len;
        logic [5:0] pat6;
        logic [3:0] pat4;

        vecs[0] = '{8'd4,   4,   2};
        vecs[1] = '{8'd5,   5,   2};
        vecs[2] = '{8'd0,   2,   1};
        vecs[3] = '{8'd1,   2,   1};
        vecs[4] = '{8'd2,   2,   1};
        vecs[5] = '{8'd3,   3,   1};
        vecs[6] = '{8'd8,   8,   4};
        vecs[7] = '{8'd255, 255, 127};

        // Reset state
        model_reset();
        #12;
        chk("rst_clkout", CLKOUT, 0);
        chk("rst_tick", TICK, 0);
        chk("rst_ack", ACK, 0);
        chk("rst_busy", BUSY, 0);
        @(negedge CLK);
        RN = 1'b1;
        step();

        // Table: period length and high-sample count per divisor
        foreach (vecs[i]) begin
            go_idle();
            load(vecs[i].div);
            EN = 1'b1;
            step();
            chk("start_tick", TICK, 1);
            chk("start_clk", CLKOUT, 1);
            highs = 1;
            len = 1;
            for (int c = 0; c < 600; c++) begin
                step();
                if (TICK) break;
                len++;
                highs += int'(CLKOUT);
            end
            chk("period_len", len, vecs[i].exp_n);
`ifdef CLKDIV_ODD50_EN
            chk("period_high", highs, vecs[i].exp_high + (vecs[i].exp_n % 2));
`else
            chk("period_high", highs, vecs[i].exp_high);
`endif
        end

        // Divisor change mid-period: REQ at cnt=1 with N=4, new N=6
        go_idle();
        load(8'd4);
        EN = 1'b1;
        step();
        step();
        DIV = 8'd6;
        REQ = 1'b1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            k++;
            if (ACK) break;
        end
        chk("ack_latency", k, 3);
        REQ = 1'b0;
        pat6[5] = CLKOUT;
        for (int b = 4; b >= 0; b--) begin
            step();
            pat6[b] = CLKOUT;
        end
        chk("pattern_n6", pat6, 6'b111000);

        // Drain: EN dropped at cnt=0 with N=8
        go_idle();
        load(8'd8);
        EN = 1'b1;
        step();
        EN = 1'b0;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            k++;
            if (!BUSY) break;
        end
        chk("drain_len", k, 8);
        chk("drain_clk", CLKOUT, 0);
        k = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            k += int'(TICK);
        end
        chk("idle_no_tick", k, 0);

        // EN re-raised during drain: period continues with no gap
        EN = 1'b1;
        step();
        EN = 1'b0;
        step();
        step();
        EN = 1'b1;
        k = 2;
        for (int c = 0; c < 20; c++) begin
            step();
            k++;
            if (TICK) break;
        end
        chk("rerun_period", k, 8);
        chk("rerun_busy", BUSY, 1);

        // Asynchronous reset mid-period, then restart at N=2
        go_idle();
        load(8'd5);
        EN = 1'b1;
        step();
        step();
        #2;
        RN = 1'b0;
        #1;
        chk("arst_clkout", CLKOUT, 0);
        chk("arst_tick", TICK, 0);
        chk("arst_ack", ACK, 0);
        chk("arst_busy", BUSY, 0);
        model_reset();
        @(negedge CLK);
        RN = 1'b1;
        for (int b = 3; b >= 0; b--) begin
            step();
            pat4[b] = CLKOUT;
        end
        chk("pattern_n2", pat4, 4'b1010);

        // Randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            if (REQ && ACK) begin
                REQ = 1'b0;
            end else if (!REQ && $urandom_range(0, 15) == 0) begin
                DIV = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
                REQ = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) EN = ~EN;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/osu_clkdiv_gen.md
# osu_clkdiv_gen

Programmable, glitch-free synchronous clock divider for the 12T cell library's clock-distribution test structures. It generates a divided clock (CLKOUT) and a one-cycle tick strobe from the root clock, and drives the clock-inverter/buffer trees under characterisation. The divide ratio is changed at runtime through a REQ/ACK handshake and only takes effect on a period boundary. Enable and disable requests never truncate a period.

## Interface
- WIDTH, 8: divisor width in bits.
- CLK  input  1  root clock; all state on rising edge, except the optional half-cycle stage.
- RN  input  1  asynchronous active-low reset.
- EN  input  1  run request; level-sensitive.
- DIV  input  WIDTH  requested divisor N; must be stable while REQ is high.
- REQ  input  1  divisor-change request; held high until ACK is seen.
- ACK  output  1  one-cycle pulse: DIV was captured into the active divisor.
- CLKOUT  output  1  divided clock.
- TICK  output  1  one-cycle pulse coincident with each CLKOUT rising edge.
- BUSY  output  1  high whenever state is not IDLE.

## Operation
- Active divisor n_q is loaded from DIV. Values 0 and 1 are clamped to 2. Maximum is 2^WIDTH−1.
- Period counter cnt runs 0..n_q−1. A period boundary is the edge where cnt==n_q−1; cnt wraps to 0 on that edge.
- Registered CLKOUT = (cnt < n_q>>1). It is high for floor(N/2) cycles and low for ceil(N/2) cycles.
- States:
  - IDLE: counter held at 0; CLKOUT=0; BUSY=0. On EN=1 go to RUN, with cnt←0, CLKOUT←1, TICK←1.
  - RUN: counting. On EN=0 go to DRAIN, which continues the current period unchanged.
  - DRAIN: counting. At the boundary go to IDLE, with CLKOUT staying 0 and no TICK. If EN=1 again, return to RUN with no gap and no extra edge.
- REQ handling:
  - In IDLE, REQ=1 loads n_q on the next edge and pulses ACK.
  - In RUN or DRAIN, the load happens only on a boundary edge; ACK pulses on that same edge. The new period starts with the new N.
  - If REQ is still high in the cycle after ACK, it is treated as a new request.
- Simultaneous events:
  - Boundary + REQ + EN=0 in DRAIN: n_q is updated, ACK pulses, and the state goes to IDLE.
  - EN=1 + REQ in IDLE: DIV is loaded on the same edge as the start, and the first period uses the new N.
- Reset: RN low forces all state and outputs low immediately: state=IDLE, cnt=0, n_q=2, CLKOUT=0, TICK=0, ACK=0, BUSY=0. Asserting reset mid-period may produce a runt CLKOUT high pulse. This is accepted and documented.

## Timing
- Start latency: CLKOUT and TICK rise on the first CLK edge that samples EN=1 in IDLE.
- Stop latency: CLKOUT is low from the boundary edge after EN falls; BUSY falls on that same edge.
- ACK latency: 1 edge after REQ in IDLE; at most n_q edges after REQ otherwise.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- CLKDIV_ODD50_EN defined:
  - Adds a falling-edge flop q_neg that samples the registered CLKOUT. It is reset asynchronously by RN.
  - For odd n_q, CLKOUT = q_pos | q_neg, so the high time is N/2 cycles (50% duty). For even n_q, q_neg is masked and output is unchanged.
  - TICK is unaffected.
- Undefined: no negedge logic; odd-N duty is floor(N/2)/N.

## Structure
- Package osu_clkdiv_pkg: state enum (IDLE, RUN, DRAIN) and the DIV_MIN=2 constant.
- Sub-module osu_clkdiv_halfcyc: the negedge stage plus the odd/even mask. It is instantiated only under CLKDIV_ODD50_EN.
- Top level holds the FSM, counter, n_q register and handshake.

## Test plan
- Reset, then EN=1 with DIV=4 → CLKOUT pattern 1100 repeating; TICK every 4 cycles; BUSY=1.
- DIV=5, macro off → pattern 11000. Macro on → CLKOUT high for 2.5 cycles.
- Running at N=4, REQ with DIV=6 asserted at cnt=1 → ACK exactly at the boundary 3 edges later; the next period is 111000; no short pulse.
- EN dropped at cnt=0 with N=8 → the period completes (4 high, 4 low); then IDLE, BUSY=0, no further TICK. EN re-raised during DRAIN → continuous pattern with no gap.
- DIV=0 and DIV=1 → behaves as N=2 (alternating 10).
- RN pulsed low mid-period → all outputs go 0 asynchronously; n_q=2; restart with EN gives the N=2 pattern.
